serial_pattern_detector: RTL and testbench
==========================================

// Module: serial_pattern_detector
//
// PURPOSE
// - Parametrised successor of the fixed "01" Moore detector: finds a programmable W-bit pattern in a serial bit stream.
// - Programmable pattern register, overlap / non-overlap mode, fill tracking and a saturating match counter.
// - Sits after the board's slow-clock shift stage. Its history, match and count outputs drive LEDR and the HEX digit displays.
//
// PARAMETERS
// - W              4        pattern / history width in bits (>= 2)
// - COUNT_WIDTH    8        match counter width
// - RESET_PATTERN  4'b1011  pattern register value after reset
//
// PORTS
// - clock          in   1            single clock, all state on posedge
// - reset          in   1            asynchronous, active-high; clears everything below
// - enable         in   1            bit strobe: in_bit is consumed on this cycle
// - in_bit         in   1            serial data bit
// - overlap        in   1            1 = overlapping matches allowed; 0 = non-overlapping
// - pattern_load   in   1            strobe: capture pattern_in
// - pattern_in     in   W            new pattern; bit 0 = oldest bit in time order
// - count_clear    in   1            strobe: zero match_count
// - history        out  W            shift register; newest bit at [W-1]
// - filled         out  1            W valid bits since last fill clear
// - match          out  1            one-cycle pulse, registered
// - match_count    out  COUNT_WIDTH  saturating number of matches
//
// BEHAVIOUR
// - Reset values: history=0, pattern=RESET_PATTERN, fill_cnt=0, state=FILL, filled=0, match=0, match_count=0.
// - Shift: on enable, history <= {in_bit, history[W-1:1]}.
//   - fill_cnt increments and saturates at W.
//   - filled = (state==SEARCH).
// - Window: next_hist = {in_bit, history[W-1:1]}.
//   - Match condition: enable && (next_hist==pattern) && (state==SEARCH || fill_cnt==W-1).
//   - match is registered: high exactly the cycle after the completing enable cycle.
//   - Latency is 1 clock.
// - FSM states:
//   - FILL -> SEARCH when fill_cnt reaches W.
//   - SEARCH stays in SEARCH on a match if overlap=1.
//   - SEARCH -> FILL with fill_cnt=0 on a match if overlap=0. The next match needs W fresh bits.
//     History is not cleared.
//   - overlap is sampled on the matching cycle only.
//   - Unused encodings -> FILL.
// - pattern_load (highest priority after reset):
//   - pattern <= pattern_in, fill_cnt <= 0, state <= FILL, match <= 0.
//   - A simultaneous enable bit still shifts into history but is not counted and cannot match.
// - match_count increments on each match pulse and saturates at all-ones (no wrap).
//   - count_clear alone -> 0.
//   - count_clear with a match event on the same edge -> 1.
//   - pattern_load does not clear the count.
// - enable=0: nothing changes except load and clear effects.
// - Reset asserted mid-stream: all outputs return to reset values immediately (asynchronous).
//   After release the detector needs W bits before the first possible match.
//
// STRUCTURE
// - Shared package/include holds:
//   - state localparams ST_FILL, ST_SEARCH (2-bit encoding)
//   - fill counter width $clog2(W+1)
// - Sub-module shift_register_param (W, enable, newest at MSB, asynchronous active-high reset to 0).
//   Provides history; the detector FSM, comparator and counter stay in the top.
//
// TESTING (W=4, pattern 4'b1011 = time order 1,1,0,1)
// - Reset, feed 1,1,0,1 with enable -> match pulse 1 cycle after 4th bit; match_count=1; filled=1 after 4th bit.
// - overlap=1, feed 1,1,0,1,1,0,1 -> match after bits 4 and 7; match_count=2.
// - overlap=0, same stream -> match after bit 4 only; count=1; filled drops to 0 after bit 4.
// - pattern_load 4'b0000 with enable on the same edge, then 4 zeros -> match only after 4th zero.
//   filled=0 in between.
// - COUNT_WIDTH=2, overlap=1, 1 then twelve 0s with pattern 0000 -> count saturates at 3 (no wrap).
//   Then count_clear coincident with a match -> count=1.
// - Assert reset mid-stream (fill_cnt=2) -> history=0, state=FILL, match=0 immediately.
//   Resume -> needs 4 bits to match.

Source files
------------

// File: rtl/serial_pattern_detector_pkg.sv
// ============================================================================
// Module : serial_pattern_detector_pkg
// Brief  : Shared state encoding and sizing helper for the pattern detector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_pattern_detector_pkg;

    localparam logic [1:0] ST_FILL   = 2'b00;
    localparam logic [1:0] ST_SEARCH = 2'b01;

    // Fill counter has to hold 0..W inclusive.
    function automatic int fill_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_pattern_detector_shift_register_param.sv
// ============================================================================
// Module : shift_register_param
// Brief  : W-bit serial-in shift register, newest bit enters at the MSB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_register_param #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_enable,
    input  logic         i_in_bit,
    output logic [W-1:0] o_history
);

    logic [W-1:0] r_history;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_history <= '0;
        end else if (i_enable) begin
            r_history <= {i_in_bit, r_history[W-1:1]};
        end
    end

    assign o_history = r_history;

endmodule

`default_nettype wire

// File: rtl/serial_pattern_detector.sv
// ============================================================================
// Module : serial_pattern_detector
// Brief  : Programmable W-bit serial pattern detector with overlap control,
//          fill tracking and a saturating match counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_pattern_detector #(
    parameter int           W             = 4,
    parameter int           COUNT_WIDTH   = 8,
    parameter logic [W-1:0] RESET_PATTERN = 4'b1011
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_bit,
    input  logic                   overlap,
    input  logic                   pattern_load,
    input  logic [W-1:0]           pattern_in,
    input  logic                   count_clear,
    output logic [W-1:0]           history,
    output logic                   filled,
    output logic                   match,
    output logic [COUNT_WIDTH-1:0] match_count
);

    import serial_pattern_detector_pkg::*;

    localparam int                  c_FILL_W    = fill_cnt_width(W);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX  = c_FILL_W'(W);
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(W - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);

    logic [W-1:0]           r_pattern;
    logic [1:0]             r_state;
    logic [c_FILL_W-1:0]    r_fill_cnt;
    logic                   r_match;
    logic [COUNT_WIDTH-1:0] r_count;

    logic [W-1:0]           w_history;
    logic [W-1:0]           w_next_hist;
    logic                   w_window_ok;
    logic                   w_hit;
    logic [c_FILL_W-1:0]    w_fill_inc;

    shift_register_param #(
        .W (W)
    ) u_shift (
        .clk       (clock),
        .rst       (reset),
        .i_enable  (enable),
        .i_in_bit  (in_bit),
        .o_history (w_history)
    );

    assign w_next_hist = {in_bit, w_history[W-1:1]};

    // The bit completing the first full window may match while still in FILL.
    assign w_window_ok = (r_state == ST_SEARCH) || (r_fill_cnt == c_FILL_LAST);
    assign w_hit       = enable && !pattern_load && w_window_ok
                         && (w_next_hist == r_pattern);
    assign w_fill_inc  = (r_fill_cnt >= c_FILL_MAX) ? c_FILL_MAX
                                                    : (r_fill_cnt + c_FILL_ONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pattern  <= RESET_PATTERN;
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
            r_match    <= 1'b0;
        end else if (pattern_load) begin
            r_pattern  <= pattern_in;
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
            r_match    <= 1'b0;
        end else begin
            r_match <= w_hit;
            case (r_state)
                ST_FILL: begin
                    if (enable) begin
                        if (w_hit && !overlap) begin
                            r_fill_cnt <= '0;
                        end else begin
                            r_fill_cnt <= w_fill_inc;
                            if (w_fill_inc == c_FILL_MAX) begin
                                r_state <= ST_SEARCH;
                            end
                        end
                    end
                end
                ST_SEARCH: begin
                    // Non-overlapping mode restarts the window; history is kept.
                    if (w_hit && !overlap) begin
                        r_state    <= ST_FILL;
                        r_fill_cnt <= '0;
                    end else if (enable) begin
                        r_fill_cnt <= w_fill_inc;
                    end
                end
                default: begin
                    r_state    <= ST_FILL;
                    r_fill_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (count_clear) begin
            r_count <= w_hit ? COUNT_WIDTH'(1) : '0;
        end else if (w_hit && (r_count != {COUNT_WIDTH{1'b1}})) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign history     = w_history;
    assign filled      = (r_state == ST_SEARCH);
    assign match       = r_match;
    assign match_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
// ============================================================================
// Module : tb_serial_pattern_detector
// Brief  : Directed and randomized checks of serial_pattern_detector against
//          a bit-queue reference model (two counter widths in parallel).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_pattern_detector;

    localparam int W = 4;

    logic       clock        = 1'b0;
    logic       reset        = 1'b1;
    logic       enable       = 1'b0;
    logic       in_bit       = 1'b0;
    logic       overlap      = 1'b1;
    logic       pattern_load = 1'b0;
    logic [3:0] pattern_in   = 4'b0000;
    logic       count_clear  = 1'b0;

    logic [3:0] history_a, history_b;
    logic       filled_a, filled_b, match_a, match_b;
    logic [7:0] count_a;
    logic [1:0] count_b;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    always #5 clock = ~clock;

    serial_pattern_detector #(.W(4), .COUNT_WIDTH(8), .RESET_PATTERN(4'b1011)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .in_bit(in_bit),
        .overlap(overlap), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .count_clear(count_clear), .history(history_a), .filled(filled_a),
        .match(match_a), .match_count(count_a)
    );

    serial_pattern_detector #(.W(4), .COUNT_WIDTH(2), .RESET_PATTERN(4'b1011)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .in_bit(in_bit),
        .overlap(overlap), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .count_clear(count_clear), .history(history_b), .filled(filled_b),
        .match(match_b), .match_count(count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the consumed bits themselves plus the number of fresh
    // bits seen since the window was last restarted.
    bit         mq[$];
    int         m_fresh = 0;
    logic [3:0] m_pat   = 4'b1011;
    bit         m_match = 1'b0;
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;

    function automatic logic [3:0] m_hist();
        logic [3:0] h;
        int n;
        h = 4'b0000;
        n = mq.size();
        for (int k = 0; k < n; k++) h[W-1-k] = mq[n-1-k];
        return h;
    endfunction

    always @(posedge clock or posedge reset) begin
        bit hit;
        int nf;
        if (reset) begin
            mq.delete();
            m_fresh = 0;
            m_pat   = 4'b1011;
            m_match = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            hit = 1'b0;
            if (enable) begin
                mq.push_back(in_bit);
                if (mq.size() > W) void'(mq.pop_front());
            end
            if (pattern_load) begin
                m_pat   = pattern_in;
                m_fresh = 0;
            end else if (enable) begin
                nf      = m_fresh + 1;
                hit     = (nf >= W) && (m_hist() == m_pat);
                m_fresh = (nf > W) ? W : nf;
                if (hit && !overlap) m_fresh = 0;
            end
            m_match = hit;
            if (count_clear) begin
                m_cnt_a = hit ? 1 : 0;
                m_cnt_b = hit ? 1 : 0;
            end else if (hit) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3)   m_cnt_b++;
            end
        end
    end

    always @(negedge clock) begin
        if (run) begin
            check("history_a", 32'(history_a), 32'(m_hist()));
            check("history_b", 32'(history_b), 32'(m_hist()));
            check("filled_a",  32'(filled_a),  32'(m_fresh >= W));
            check("filled_b",  32'(filled_b),  32'(m_fresh >= W));
            check("match_a",   32'(match_a),   32'(m_match));
            check("match_b",   32'(match_b),   32'(m_match));
            check("count_a",   32'(count_a),   32'(m_cnt_a));
            check("count_b",   32'(count_b),   32'(m_cnt_b));
        end
    end

    task automatic send(input logic en, input logic b);
        enable = en;
        in_bit = b;
        @(posedge clock);
        #1;
    endtask

    // Called just after a posedge: pulse reset mid-cycle, then realign.
    task automatic do_reset();
        reset = 1'b1;
        #6;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    logic [6:0] seq7;
    logic [6:0] mask7;
    logic [5:0] seq6;
    logic [5:0] mask6;
    logic [3:0] mask4;
    int         pulses;

    initial begin
        seq7 = 7'b1011011;  // bit i = i-th bit in time order: 1,1,0,1,1,0,1
        seq6 = 6'b101110;   // 0,1,1,1,0,1

        repeat (2) @(posedge clock);
        #1;
        check("rst_history", 32'(history_a), 32'h0);
        check("rst_filled",  32'(filled_a),  32'h0);
        check("rst_match",   32'(match_a),   32'h0);
        check("rst_count",   32'(count_a),   32'h0);
        reset = 1'b0;
        run   = 1'b1;

        // Basic detection of 1,1,0,1
        overlap = 1'b1;
        send(1, 1); send(1, 1); send(1, 0);
        check("t1_match_early",  32'(match_a),  32'h0);
        check("t1_filled_early", 32'(filled_a), 32'h0);
        send(1, 1);
        check("t1_match",   32'(match_a),   32'h1);
        check("t1_count",   32'(count_a),   32'h1);
        check("t1_filled",  32'(filled_a),  32'h1);
        check("t1_history", 32'(history_a), 32'hB);
        send(0, 0);
        check("t1_pulse_end", 32'(match_a), 32'h0);

        // Overlapping stream
        do_reset();
        overlap = 1'b1;
        mask7 = '0;
        for (int i = 0; i < 7; i++) begin
            send(1, seq7[i]);
            mask7[i] = match_a;
        end
        check("t2_pulses", 32'(mask7),   32'h48);
        check("t2_count",  32'(count_a), 32'h2);

        // Non-overlapping stream
        do_reset();
        overlap = 1'b0;
        mask7 = '0;
        for (int i = 0; i < 7; i++) begin
            send(1, seq7[i]);
            mask7[i] = match_a;
            if (i == 3) check("t3_filled_after4", 32'(filled_a), 32'h0);
        end
        check("t3_pulses", 32'(mask7),   32'h08);
        check("t3_count",  32'(count_a), 32'h1);

        // Pattern load coincident with an enabled bit
        do_reset();
        overlap = 1'b1;
        send(1, 1); send(1, 1);
        pattern_load = 1'b1;
        pattern_in   = 4'b0000;
        send(1, 0);
        pattern_load = 1'b0;
        check("t4_load_match", 32'(match_a), 32'h0);
        mask4 = '0;
        for (int i = 0; i < 4; i++) begin
            send(1, 0);
            mask4[i] = match_a;
            if (i == 2) check("t4_filled_mid", 32'(filled_a), 32'h0);
        end
        check("t4_pulses", 32'(mask4),   32'h8);
        check("t4_count",  32'(count_a), 32'h1);

        // Saturation of the narrow counter, then clear coincident with a match
        send(1, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            send(1, 0);
            if (match_a) pulses++;
        end
        check("t5_pulses",  32'(pulses),  32'd9);
        check("t5_count_b", 32'(count_b), 32'h3);
        check("t5_count_a", 32'(count_a), 32'd10);
        count_clear = 1'b1;
        send(1, 0);
        count_clear = 1'b0;
        check("t5_clr_match",   32'(match_b), 32'h1);
        check("t5_clr_count_b", 32'(count_b), 32'h1);
        check("t5_clr_count_a", 32'(count_a), 32'h1);

        // Asynchronous reset mid-stream
        do_reset();
        overlap = 1'b1;
        send(1, 1); send(1, 1);
        enable = 1'b0;
        check("t6_pre_history", 32'(history_a), 32'hC);
        reset = 1'b1;
        #1;
        check("t6_async_history", 32'(history_a), 32'h0);
        check("t6_async_filled",  32'(filled_a),  32'h0);
        check("t6_async_match",   32'(match_a),   32'h0);
        check("t6_async_count",   32'(count_a),   32'h0);
        #5;
        reset = 1'b0;
        @(posedge clock);
        #1;
        mask6 = '0;
        for (int i = 0; i < 6; i++) begin
            send(1, seq6[i]);
            mask6[i] = match_a;
        end
        check("t6_pulses", 32'(mask6), 32'h20);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable       = (($urandom % 4) != 0);
            in_bit       = 1'($urandom % 2);
            overlap      = 1'($urandom % 2);
            pattern_load = (($urandom % 48) == 0);
            pattern_in   = 4'($urandom);
            count_clear  = (($urandom % 40) == 0);
            if (($urandom % 300) == 0) begin
                do_reset();
            end else begin
                @(posedge clock);
                #1;
            end
        end

        enable       = 1'b0;
        pattern_load = 1'b0;
        count_clear  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
